// File: rtl/envelope_generator.sv
// ADSR amplitude envelope for one tone-generator voice. A gate-driven state
// machine sweeps an 8-bit level, and the level scales the incoming waveform sample.
module envelope_generator #(
   parameter int DATA_BITS     = 12,
   parameter int BASE_DIV      = 4,
   parameter int PRESCALE_BITS = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 gate,
   input  logic [3:0]           attack,
   input  logic [3:0]           decay,
   input  logic [3:0]           sustain,
   input  logic [3:0]           rel,
   input  logic [DATA_BITS-1:0] din,
   output logic [DATA_BITS-1:0] dout,
   output logic [7:0]           env_level,
   output logic [2:0]           env_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } state_t;

   state_t                   state_q, state_d;
   logic [7:0]               level_q, level_d;
   logic [PRESCALE_BITS-1:0] count_q, count_d;
   logic [DATA_BITS-1:0]     dout_q, dout_d;
   logic                     gate_q;

   logic                     rise, fall, active, tick;
   logic [3:0]               rate;
   logic [PRESCALE_BITS-1:0] period_m1;
   logic [7:0]               target;
   logic [DATA_BITS+7:0]     product;

   assign rise   = gate & ~gate_q;
   assign fall   = ~gate & gate_q;
   // Nibble duplication is sustain*17, mapping code 0..15 onto 0..255.
   assign target = {sustain, sustain};

   always_comb begin
      rate   = attack;
      active = 1'b0;
      case (state_q)
         ATTACK:  begin rate = attack; active = 1'b1; end
         DECAY:   begin rate = decay;  active = 1'b1; end
         RELEASE: begin rate = rel;    active = 1'b1; end
         default: begin rate = attack; active = 1'b0; end
      endcase
   end

   assign period_m1 = (PRESCALE_BITS'(BASE_DIV) << rate) - PRESCALE_BITS'(1);
   // Greater-or-equal so that shortening the rate mid-count ticks right away.
   assign tick      = active && (count_q >= period_m1);

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      if (!active || tick)
         count_d = '0;
      else
         count_d = count_q + PRESCALE_BITS'(1);

      if (rise) begin
         state_d = ATTACK;
         count_d = '0;
      end else if (fall && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
         state_d = RELEASE;
         count_d = '0;
      end else if (state_q == ATTACK && level_q == 8'd255) begin
         state_d = DECAY;
         count_d = '0;
      end else if (state_q == DECAY && level_q <= target) begin
         state_d = SUSTAIN;
         count_d = '0;
      end else if (state_q == RELEASE && level_q == 8'd0) begin
         state_d = IDLE;
         count_d = '0;
      end else if (tick) begin
         case (state_q)
            ATTACK:  if (level_q != 8'd255)  level_d = level_q + 8'd1;
            DECAY:   if (level_q > target)   level_d = level_q - 8'd1;
            RELEASE: if (level_q != 8'd0)    level_d = level_q - 8'd1;
            default: level_d = level_q;
         endcase
      end
   end

   assign product = {8'd0, din} * {{DATA_BITS{1'b0}}, level_q};
   assign dout_d  = DATA_BITS'(product >> 8);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         level_q <= '0;
         count_q <= '0;
         dout_q  <= '0;
         gate_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         count_q <= count_d;
         dout_q  <= dout_d;
         gate_q  <= gate;
      end
   end

   assign dout      = dout_q;
   assign env_level = level_q;
   assign env_state = state_q;

endmodule

// File: tb/tb_envelope_generator.sv
// Directed bench for envelope_generator: sample-scaling vector tables plus
// hand-timed ADSR, retrigger, early-release, rate-change and async-reset sequences.
module tb_envelope_generator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        gate = 1'b0;
   logic [3:0]  attack = 4'd0;
   logic [3:0]  decay = 4'd0;
   logic [3:0]  sustain = 4'd0;
   logic [3:0]  rel = 4'd0;
   logic [11:0] din = 12'd0;
   logic [11:0] dout;
   logic [7:0]  env_level;
   logic [2:0]  env_state;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [11:0] din;
      logic [11:0] exp255;
      logic [11:0] exp136;
   } vec_t;

   vec_t vecs[6];

   envelope_generator #(
      .DATA_BITS(12),
      .BASE_DIV(4),
      .PRESCALE_BITS(20)
   ) dut (
      .clk(clk),
      .rst(rst),
      .gate(gate),
      .attack(attack),
      .decay(decay),
      .sustain(sustain),
      .rel(rel),
      .din(din),
      .dout(dout),
      .env_level(env_level),
      .env_state(env_state)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Advance n rising edges, landing on the following falling edge.
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [11:0] d);
      din = d;
      step(1);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkEnv(input string name, input int st, input int lvl);
      checkOutput({name, ".state"}, 32'(env_state), 32'(st));
      checkOutput({name, ".level"}, 32'(env_level), 32'(lvl));
   endtask

   // Main sequence: every wait is a fixed number of clocks, so the run always ends.
   initial begin
      vecs[0] = '{12'd4095, 12'd4079, 12'd2175};
      vecs[1] = '{12'd2048, 12'd2040, 12'd1088};
      vecs[2] = '{12'd1,    12'd0,    12'd0};
      vecs[3] = '{12'd256,  12'd255,  12'd136};
      vecs[4] = '{12'd1000, 12'd996,  12'd531};
      vecs[5] = '{12'd0,    12'd0,    12'd0};

      step(2);
      checkEnv("reset", 0, 0);
      checkOutput("reset.dout", 32'(dout), 32'd0);

      // Full ADSR: attack=0 decay=0 sustain=8 rel=1.
      attack = 4'd0; decay = 4'd0; sustain = 4'd8; rel = 4'd1; din = 12'd4095;
      rst = 1'b0;
      step(2);
      checkEnv("idle_before_gate", 0, 0);
      gate = 1'b1;
      step(1);    checkEnv("adsr.enter_attack", 1, 0);
      step(4);    checkEnv("adsr.first_step", 1, 1);
      step(1015); checkEnv("adsr.att_254", 1, 254);
      step(1);    checkEnv("adsr.att_255", 1, 255);
      step(1);    checkEnv("adsr.enter_decay", 2, 255);
      checkOutput("adsr.dout_255", 32'(dout), 32'd4079);
      step(475);  checkEnv("adsr.dec_137", 2, 137);
      step(1);    checkEnv("adsr.dec_136", 2, 136);
      step(1);    checkEnv("adsr.enter_sustain", 3, 136);
      step(100);  checkEnv("adsr.sustain_hold", 3, 136);
      sustain = 4'd2;
      step(20);   checkEnv("adsr.sustain_code_change", 3, 136);
      sustain = 4'd8;

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].din);
         checkOutput($sformatf("scale136[%0d]", i), 32'(dout), 32'(vecs[i].exp136));
      end

      din = 12'd4095;
      gate = 1'b0;
      step(1);    checkEnv("adsr.enter_release", 4, 136);
      step(1087); checkEnv("adsr.rel_1", 4, 1);
      step(1);    checkEnv("adsr.rel_0", 4, 0);
      step(1);    checkEnv("adsr.enter_idle", 0, 0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].din);
         checkOutput($sformatf("scale_idle[%0d]", i), 32'(dout), 32'd0);
      end

      // Early release from attack at level 50.
      gate = 1'b1;
      step(1);    checkEnv("early.enter_attack", 1, 0);
      step(200);  checkEnv("early.att_50", 1, 50);
      gate = 1'b0;
      step(1);    checkEnv("early.enter_release", 4, 50);
      step(7);    checkEnv("early.rel_hold", 4, 50);
      step(1);    checkEnv("early.rel_49", 4, 49);
      step(8);    checkEnv("early.rel_48", 4, 48);
      step(384);  checkEnv("early.rel_0", 4, 0);
      step(1);    checkEnv("early.idle", 0, 0);

      // Sustain code 15: decay passes straight to sustain at 255.
      sustain = 4'd15;
      gate = 1'b1;
      step(1);    checkEnv("s15.enter_attack", 1, 0);
      step(1020); checkEnv("s15.att_255", 1, 255);
      step(1);    checkEnv("s15.enter_decay", 2, 255);
      step(1);    checkEnv("s15.enter_sustain", 3, 255);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].din);
         checkOutput($sformatf("scale255[%0d]", i), 32'(dout), 32'(vecs[i].exp255));
      end

      // Retrigger during release at level 100.
      rel = 4'd0;
      gate = 1'b0;
      step(1);    checkEnv("retrig.enter_release", 4, 255);
      step(620);  checkEnv("retrig.rel_100", 4, 100);
      gate = 1'b1;
      step(1);    checkEnv("retrig.enter_attack", 1, 100);
      step(3);    checkEnv("retrig.hold_100", 1, 100);
      step(1);    checkEnv("retrig.att_101", 1, 101);

      // Rate change mid-count: period 32 with count at 20, then back to period 4.
      attack = 4'd3;
      step(20);   checkEnv("rate.slow_count20", 1, 101);
      attack = 4'd0;
      step(1);    checkEnv("rate.immediate_tick", 1, 102);
      step(3);    checkEnv("rate.hold_102", 1, 102);
      step(1);    checkEnv("rate.att_103", 1, 103);

      // Gate fall on the same clock as an attack tick: the edge wins.
      step(3);    checkEnv("edge_tick.pre", 1, 103);
      gate = 1'b0;
      step(1);    checkEnv("edge_tick.release_no_step", 4, 103);
      step(3);    checkEnv("edge_tick.rel_hold", 4, 103);
      step(1);    checkEnv("edge_tick.rel_102", 4, 102);

      // Asynchronous reset in the middle of decay, gate held high through release.
      sustain = 4'd0;
      gate = 1'b1;
      step(1);    checkEnv("mid.enter_attack", 1, 102);
      step(612);  checkEnv("mid.att_255", 1, 255);
      step(1);    checkEnv("mid.enter_decay", 2, 255);
      step(10);   checkEnv("mid.dec_253", 2, 253);
      #2 rst = 1'b1;
      #1;
      checkEnv("async_reset", 0, 0);
      checkOutput("async_reset.dout", 32'(dout), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      din = 12'd2048;
      step(1);    checkEnv("post_reset.attack", 1, 0);
      step(3);    checkEnv("post_reset.hold_0", 1, 0);
      step(1);    checkEnv("post_reset.level_1", 1, 1);
      step(508);  checkEnv("post_reset.level_128", 1, 128);
      step(1);
      checkOutput("scale128.dout", 32'(dout), 32'd1024);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
